// File: rtl/rr_req_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_req_queue                                                             |
// | Per-agent pending-request counters feeding a round-robin arbiter, with   |
// | sticky overflow / spurious / multi-grant / starvation debug flags.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rr_req_queue #(
   parameter int NumOfAgents  = 4,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NumOfAgents-1:0] req_in,
   output logic [NumOfAgents-1:0] req_full,
   output logic [NumOfAgents-1:0] arb_req,
   input  logic [NumOfAgents-1:0] arb_grant,
   output logic [NumOfAgents-1:0] overflow,
   output logic                   spurious_grant,
   output logic                   multi_grant,
   output logic [NumOfAgents-1:0] starve
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int WW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
   localparam logic [WW-1:0] C_LIMIT = WW'(STARVE_LIMIT);

   logic [CW-1:0]          cnt_q  [NumOfAgents];
   logic [CW-1:0]          cnt_d  [NumOfAgents];
   logic [WW-1:0]          wait_q [NumOfAgents];
   logic [WW-1:0]          wait_d [NumOfAgents];
   logic [NumOfAgents-1:0] overflow_q, overflow_d;
   logic [NumOfAgents-1:0] starve_q, starve_d;
   logic                   spurious_grant_q, spurious_grant_d;
   logic                   multi_grant_q, multi_grant_d;
   logic [NumOfAgents-1:0] grant_ok;

   // A grant only counts against an agent that actually has something pending.
   assign grant_ok = arb_grant & arb_req;

   always_comb begin
      cnt_d            = cnt_q;
      wait_d           = wait_q;
      overflow_d       = overflow_q;
      starve_d         = starve_q;
      spurious_grant_d = spurious_grant_q;
      multi_grant_d    = multi_grant_q | ($countones(arb_grant) > 1);
      for (int i = 0; i < NumOfAgents; i++) begin
         if (arb_grant[i] && !arb_req[i]) begin
            spurious_grant_d = 1'b1;
         end
         if (req_in[i] && !grant_ok[i]) begin
            if (cnt_q[i] == C_DEPTH) begin
               overflow_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end else if (!req_in[i] && grant_ok[i]) begin
            cnt_d[i] = cnt_q[i] - 1'b1;
         end
         if (!arb_req[i] || grant_ok[i]) begin
            wait_d[i] = '0;
         end else if (wait_q[i] != C_LIMIT) begin
            wait_d[i] = wait_q[i] + 1'b1;
         end
         if (wait_d[i] == C_LIMIT) begin
            starve_d[i] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NumOfAgents; i++) begin
            cnt_q[i]  <= '0;
            wait_q[i] <= '0;
         end
         overflow_q       <= '0;
         starve_q         <= '0;
         spurious_grant_q <= 1'b0;
         multi_grant_q    <= 1'b0;
      end else begin
         cnt_q            <= cnt_d;
         wait_q           <= wait_d;
         overflow_q       <= overflow_d;
         starve_q         <= starve_d;
         spurious_grant_q <= spurious_grant_d;
         multi_grant_q    <= multi_grant_d;
      end
   end

   generate
      for (genvar gi = 0; gi < NumOfAgents; gi++) begin : g_decode
         assign arb_req[gi]  = (cnt_q[gi] != '0);
         assign req_full[gi] = (cnt_q[gi] == C_DEPTH);
      end
   endgenerate

   assign overflow       = overflow_q;
   assign starve         = starve_q;
   assign spurious_grant = spurious_grant_q;
   assign multi_grant    = multi_grant_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_req_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rr_req_queue                                                          |
// | Scenario tasks plus randomized traffic against a behavioural model.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_rr_req_queue;

   localparam int N     = 4;
   localparam int DEPTH = 4;
   localparam int LIMIT = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req_in = '0;
   logic [N-1:0] arb_grant = '0;
   logic [N-1:0] req_full, arb_req, overflow, starve;
   logic         spurious_grant, multi_grant;

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural reference state
   int m_cnt  [N];
   int m_wait [N];
   bit m_ovf  [N];
   bit m_stv  [N];
   bit m_spur;
   bit m_multi;

   rr_req_queue #(.NumOfAgents(N), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst), .req_in(req_in), .req_full(req_full),
      .arb_req(arb_req), .arb_grant(arb_grant), .overflow(overflow),
      .spurious_grant(spurious_grant), .multi_grant(multi_grant),
      .starve(starve)
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] exp_req();
      logic [N-1:0] v = '0;
      for (int i = 0; i < N; i++) v[i] = (m_cnt[i] > 0);
      return v;
   endfunction

   function automatic logic [N-1:0] exp_full();
      logic [N-1:0] v = '0;
      for (int i = 0; i < N; i++) v[i] = (m_cnt[i] == DEPTH);
      return v;
   endfunction

   function automatic logic [N-1:0] exp_ovf();
      logic [N-1:0] v = '0;
      for (int i = 0; i < N; i++) v[i] = m_ovf[i];
      return v;
   endfunction

   function automatic logic [N-1:0] exp_stv();
      logic [N-1:0] v = '0;
      for (int i = 0; i < N; i++) v[i] = m_stv[i];
      return v;
   endfunction

   task automatic model_step(input logic r, input logic [N-1:0] req, input logic [N-1:0] gnt);
      int ones = 0;
      if (r) begin
         for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0; m_wait[i] = 0; m_ovf[i] = 0; m_stv[i] = 0;
         end
         m_spur = 0; m_multi = 0;
         return;
      end
      for (int i = 0; i < N; i++) ones += int'(gnt[i]);
      if (ones > 1) m_multi = 1;
      for (int i = 0; i < N; i++) begin
         int  old   = m_cnt[i];
         bit  valid = gnt[i] && old > 0;
         if (gnt[i] && old == 0) m_spur = 1;
         if (req[i] && !valid) begin
            if (old < DEPTH) m_cnt[i] = old + 1;
            else m_ovf[i] = 1;
         end else if (!req[i] && valid) begin
            m_cnt[i] = old - 1;
         end
         if (old == 0 || valid) m_wait[i] = 0;
         else if (m_wait[i] < LIMIT) m_wait[i] = m_wait[i] + 1;
         if (m_wait[i] == LIMIT) m_stv[i] = 1;
      end
   endtask

   // Drive one cycle of inputs, advance the model at the edge, settle after it.
   task automatic cycle(input logic r, input logic [N-1:0] req, input logic [N-1:0] gnt);
      rst = r; req_in = req; arb_grant = gnt;
      @(posedge clk);
      model_step(r, req, gnt);
      #1;
      rst = 1'b0; req_in = '0; arb_grant = '0;
   endtask

   task automatic do_reset();
      cycle(1'b1, '0, '0);
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) cycle(1'b1, 4'b1111, '0);
      n_cmp++;
      if ({arb_req, req_full, overflow, starve, spurious_grant, multi_grant} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs got req=%b full=%b ovf=%b stv=%b sp=%b mg=%b exp all 0",
                  arb_req, req_full, overflow, starve, spurious_grant, multi_grant);
      end
      cycle(1'b0, 4'b0001, '0);
      n_cmp++;
      if (arb_req !== 4'b0001) begin
         n_err++; $display("FAIL reset_first_req arb_req got %b exp 0001", arb_req);
      end
   endtask

   task automatic test_queue_drain();
      do_reset();
      for (int k = 0; k < 3; k++) cycle(1'b0, 4'b0100, '0);
      for (int k = 0; k < 3; k++) begin
         cycle(1'b0, '0, 4'b0100);
         n_cmp++;
         if (arb_req[2] !== (k < 2)) begin
            n_err++; $display("FAIL drain_grant%0d arb_req[2] got %b exp %b", k, arb_req[2], k < 2);
         end
      end
      n_cmp++;
      if ({overflow, starve, spurious_grant, multi_grant, arb_req} !== '0) begin
         n_err++;
         $display("FAIL drain_flags got ovf=%b stv=%b sp=%b mg=%b req=%b exp all 0",
                  overflow, starve, spurious_grant, multi_grant, arb_req);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         cycle(1'b0, 4'b0001, '0);
         n_cmp++;
         if (req_full[0] !== (k >= 3) || overflow[0] !== (k == 4)) begin
            n_err++;
            $display("FAIL overflow_pulse%0d full=%b ovf=%b exp full=%b ovf=%b",
                     k, req_full[0], overflow[0], k >= 3, k == 4);
         end
      end
      for (int k = 0; k < 4; k++) begin
         cycle(1'b0, '0, 4'b0001);
         n_cmp++;
         if (arb_req[0] !== (k < 3) || req_full[0] !== 1'b0) begin
            n_err++;
            $display("FAIL overflow_drain%0d req=%b full=%b exp req=%b full=0",
                     k, arb_req[0], req_full[0], k < 3);
         end
      end
   endtask

   task automatic test_full_simul();
      do_reset();
      for (int k = 0; k < 4; k++) cycle(1'b0, 4'b0010, '0);
      cycle(1'b0, 4'b0010, 4'b0010);
      n_cmp++;
      if (req_full[1] !== 1'b1 || overflow[1] !== 1'b0) begin
         n_err++;
         $display("FAIL full_simul full=%b ovf=%b exp full=1 ovf=0", req_full[1], overflow[1]);
      end
      for (int k = 0; k < 4; k++) cycle(1'b0, '0, 4'b0010);
      n_cmp++;
      if (arb_req !== 4'b0000 || spurious_grant !== 1'b0) begin
         n_err++;
         $display("FAIL full_simul_drain req=%b sp=%b exp req=0000 sp=0", arb_req, spurious_grant);
      end
   endtask

   task automatic test_grant_errors();
      do_reset();
      cycle(1'b0, '0, 4'b1000);
      n_cmp++;
      if (spurious_grant !== 1'b1 || arb_req !== 4'b0000 || multi_grant !== 1'b0) begin
         n_err++;
         $display("FAIL spurious got sp=%b req=%b mg=%b exp sp=1 req=0000 mg=0",
                  spurious_grant, arb_req, multi_grant);
      end
      do_reset();
      cycle(1'b0, 4'b0011, '0);
      cycle(1'b0, '0, 4'b0011);
      n_cmp++;
      if (multi_grant !== 1'b1 || arb_req !== 4'b0000 || spurious_grant !== 1'b0) begin
         n_err++;
         $display("FAIL multi_grant got mg=%b req=%b sp=%b exp mg=1 req=0000 sp=0",
                  multi_grant, arb_req, spurious_grant);
      end
   endtask

   task automatic test_starve();
      do_reset();
      cycle(1'b0, 4'b1000, '0);
      for (int k = 1; k <= LIMIT; k++) begin
         cycle(1'b0, '0, '0);
         n_cmp++;
         if (starve[3] !== (k == LIMIT)) begin
            n_err++; $display("FAIL starve_edge%0d starve[3] got %b exp %b", k, starve[3], k == LIMIT);
         end
      end
      do_reset();
      cycle(1'b0, 4'b1000, '0);
      for (int k = 1; k < LIMIT - 1; k++) cycle(1'b0, '0, '0);
      cycle(1'b0, '0, 4'b1000);
      cycle(1'b0, 4'b1000, '0);
      for (int k = 1; k < LIMIT; k++) cycle(1'b0, '0, '0);
      n_cmp++;
      if (starve[3] !== 1'b0 || arb_req[3] !== 1'b1) begin
         n_err++;
         $display("FAIL starve_granted starve[3]=%b req[3]=%b exp starve=0 req=1", starve[3], arb_req[3]);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         logic [N-1:0] req, gnt, pend;
         int sel;
         req  = N'($urandom);
         pend = exp_req();
         sel  = $urandom_range(0, 9);
         gnt  = '0;
         if (sel <= 4 && pend != '0) begin
            int b;
            do b = $urandom_range(0, N - 1); while (!pend[b]);
            gnt[b] = 1'b1;
         end else if (sel == 7) begin
            gnt = N'($urandom);
         end else if (sel >= 8) begin
            gnt[$urandom_range(0, N - 1)] = 1'b1;
         end
         if (sel <= 2) req = req & N'($urandom);
         cycle(($urandom_range(0, 79) == 0), req, gnt);
         n_cmp++;
         if (arb_req !== exp_req() || req_full !== exp_full() || overflow !== exp_ovf() ||
             starve !== exp_stv() || spurious_grant !== m_spur || multi_grant !== m_multi) begin
            n_err++;
            $display("FAIL random_c%0d got req=%b full=%b ovf=%b stv=%b sp=%b mg=%b exp req=%b full=%b ovf=%b stv=%b sp=%b mg=%b",
                     c, arb_req, req_full, overflow, starve, spurious_grant, multi_grant,
                     exp_req(), exp_full(), exp_ovf(), exp_stv(), m_spur, m_multi);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         m_cnt[i] = 0; m_wait[i] = 0; m_ovf[i] = 0; m_stv[i] = 0;
      end
      m_spur = 0; m_multi = 0;
      test_reset();
      test_queue_drain();
      test_overflow();
      test_full_simul();
      test_grant_errors();
      test_starve();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
